// File: rtl/ahb2apb3_pkg.sv
// Shared types and bus encodings for the AHB-Lite to APB3 bridge.
package ahb2apb3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

endpackage

// File: rtl/apb3_slave_mux.sv
// One-hot PSEL decode and return-path selection for the addressed APB slave.
module apb3_slave_mux #(
  parameter int NUM_SLV = 4,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 2
) (
  input  logic [IDX_W-1:0]          idx,
  input  logic                      en,
  output logic [NUM_SLV-1:0]        psel,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr,
  output logic [DATA_W-1:0]         sel_prdata,
  output logic                      sel_pready,
  output logic                      sel_pslverr
);

  // An index past NUM_SLV matches no lane: no select, no ready, no data.
  always_comb begin
    psel        = '0;
    sel_prdata  = '0;
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx == IDX_W'(i)) begin
        psel[i]     = en;
        sel_prdata  = prdata[i*DATA_W +: DATA_W];
        sel_pready  = pready[i];
        sel_pslverr = pslverr[i];
      end
    end
  end

endmodule

// File: rtl/ahb2apb3_mux_bridge.sv
// AHB-Lite slave to multi-slave APB3 bridge; FSM and bus registers live here.
module ahb2apb3_mux_bridge
  import ahb2apb3_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SLV_AW  = 12,
  parameter int TIMEOUT = 256
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      HSEL,
  input  logic                      HREADY,
  input  logic [ADDR_W-1:0]         HADDR,
  input  logic [1:0]                HTRANS,
  input  logic                      HWRITE,
  input  logic [DATA_W-1:0]         HWDATA,
  output logic [DATA_W-1:0]         HRDATA,
  output logic                      HREADYOUT,
  output logic [1:0]                HRESP,
  output logic [ADDR_W-1:0]         PADDR,
  output logic                      PWRITE,
  output logic                      PENABLE,
  output logic [DATA_W-1:0]         PWDATA,
  output logic [NUM_SLV-1:0]        PSEL,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int IDX_W = (NUM_SLV <= 1) ? 1 : $clog2(NUM_SLV);

  state_t             state, nxt;
  logic [IDX_W-1:0]   slv_idx;
  logic [15:0]        wait_cnt;
  logic               xfer_req, valid, capture, idx_bad, timeout_hit, mux_en;
  logic [DATA_W-1:0]  sel_prdata;
  logic               sel_pready, sel_pslverr;

  always_comb begin
    case (HTRANS)
      HTRANS_NONSEQ, HTRANS_SEQ: xfer_req = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  xfer_req = 1'b0;
      default:                   xfer_req = 1'b0;
    endcase
  end

  assign valid       = HSEL & HREADY & xfer_req;
  assign capture     = valid && (state == ST_IDLE || state == ST_ERR2);
  assign idx_bad     = (32'(slv_idx) >= 32'(NUM_SLV));
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == 16'(TIMEOUT - 1));

  apb3_slave_mux #(.NUM_SLV(NUM_SLV), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_mux (
    .idx(slv_idx), .en(mux_en), .psel(PSEL),
    .prdata(PRDATA), .pready(PREADY), .pslverr(PSLVERR),
    .sel_prdata(sel_prdata), .sel_pready(sel_pready), .sel_pslverr(sel_pslverr)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt       = state;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    PENABLE   = 1'b0;
    mux_en    = 1'b0;
    case (state)
      ST_IDLE:  if (valid) nxt = ST_WDATA;
      ST_WDATA: begin
        HREADYOUT = 1'b0;
        nxt       = idx_bad ? ST_ERR1 : ST_SETUP;
      end
      ST_SETUP: begin
        HREADYOUT = 1'b0;
        mux_en    = 1'b1;
        nxt       = ST_ACCESS;
      end
      ST_ACCESS: begin
        HREADYOUT = 1'b0;
        mux_en    = 1'b1;
        PENABLE   = 1'b1;
        // A ready in the same cycle as the timeout still completes normally.
        if (sel_pready)       nxt = sel_pslverr ? ST_ERR1 : ST_IDLE;
        else if (timeout_hit) nxt = ST_ERR1;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        nxt       = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP = HRESP_ERROR;
        nxt   = valid ? ST_WDATA : ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      PADDR    <= '0;
      PWRITE   <= 1'b0;
      PWDATA   <= '0;
      HRDATA   <= '0;
      slv_idx  <= '0;
      wait_cnt <= '0;
    end else begin
      if (capture) begin
        PADDR   <= HADDR;
        PWRITE  <= HWRITE;
        slv_idx <= HADDR[SLV_AW+IDX_W-1:SLV_AW];
      end
      if (state == ST_WDATA && PWRITE) PWDATA <= HWDATA;
      if (state == ST_SETUP)
        wait_cnt <= '0;
      else if (state == ST_ACCESS && !sel_pready)
        wait_cnt <= wait_cnt + 16'd1;
      if (state == ST_ACCESS && sel_pready && !sel_pslverr && !PWRITE)
        HRDATA <= sel_prdata;
    end
  end

endmodule

// File: tb/tb_ahb2apb3_mux_bridge.sv
// Scoreboard bench: a 4-slave bridge (TIMEOUT=8) and a 3-slave bridge for the unmapped-index case.
module tb_ahb2apb3_mux_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel, hsel3, hready, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;

  logic [31:0]  hrdata, paddr, pwdata;
  logic         hreadyout, pwrite, penable;
  logic [1:0]   hresp;
  logic [3:0]   psel, pready, pslverr;
  logic [127:0] prdata;

  logic [31:0] hrdata3, paddr3, pwdata3;
  logic        hreadyout3, pwrite3, penable3;
  logic [1:0]  hresp3;
  logic [2:0]  psel3;

  always #5 clk = ~clk;

  ahb2apb3_mux_bridge #(.NUM_SLV(4), .TIMEOUT(8)) u_dut (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel), .HREADY(hready), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HWDATA(hwdata), .HRDATA(hrdata),
    .HREADYOUT(hreadyout), .HRESP(hresp), .PADDR(paddr), .PWRITE(pwrite),
    .PENABLE(penable), .PWDATA(pwdata), .PSEL(psel), .PRDATA(prdata),
    .PREADY(pready), .PSLVERR(pslverr)
  );

  ahb2apb3_mux_bridge #(.NUM_SLV(3)) u_dut3 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel3), .HREADY(hready), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HWDATA(hwdata), .HRDATA(hrdata3),
    .HREADYOUT(hreadyout3), .HRESP(hresp3), .PADDR(paddr3), .PWRITE(pwrite3),
    .PENABLE(penable3), .PWDATA(pwdata3), .PSEL(psel3), .PRDATA(96'h0),
    .PREADY(3'b111), .PSLVERR(3'b000)
  );

  // APB slave models: slave i answers after slv_wait[i] ACCESS cycles.
  int          slv_wait [4];
  logic [31:0] slv_rd   [4];
  logic [3:0]  slv_err, slv_hang;
  logic        noise, pulse0;
  int          acc_cnt;

  always @(posedge clk) acc_cnt <= penable ? acc_cnt + 1 : 0;

  always_comb begin
    pready  = '0;
    pslverr = '0;
    prdata  = '0;
    for (int i = 0; i < 4; i++) begin
      prdata[i*32 +: 32] = slv_rd[i];
      if (psel[i] && penable && !slv_hang[i] && acc_cnt >= slv_wait[i]) begin
        pready[i]  = 1'b1;
        pslverr[i] = slv_err[i];
      end
      if (noise && !psel[i]) begin
        pready[i]  = 1'b1;
        pslverr[i] = 1'b1;
      end
    end
    pready[0] = pready[0] | pulse0;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          waits;
    int          pen;
    logic [3:0]  psel;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hrdata = '0;

  function automatic exp_t model(input logic [31:0] addr, input logic wr);
    exp_t e;
    int   idx = int'(addr[13:12]);
    logic bad = slv_err[idx] | slv_hang[idx];
    e.psel  = 4'b0001 << idx;
    e.pen   = slv_hang[idx] ? 8 : slv_wait[idx] + 1;
    e.waits = 2 + e.pen + (bad ? 1 : 0);
    e.resp  = bad ? 2'b01 : 2'b00;
    if (!wr && !bad) m_hrdata = slv_rd[idx];
    e.rdata = m_hrdata;
    return e;
  endfunction

  // Drives an address phase at the current time (just after an edge) and
  // returns once HREADYOUT rises, i.e. in IDLE or ERR2.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd);
    exp_t        e;
    int          waits = 0, pen = 0;
    logic [1:0]  resp_lo = 2'b00;
    logic [3:0]  c_psel = '0;
    logic [31:0] c_paddr = '0, c_pwdata = '0;
    logic        stable = 1'b1, onehot = 1'b1;
    sb.push_back(model(addr, wr));
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    while (hreadyout == 1'b0 && waits < 40) begin
      waits++;
      resp_lo = hresp;
      if ((psel & (psel - 4'd1)) != 4'd0) onehot = 1'b0;
      if (penable) begin
        if (pen == 0) begin
          c_psel = psel; c_paddr = paddr; c_pwdata = pwdata;
        end else if (psel != c_psel || paddr != c_paddr || pwdata != c_pwdata || pwrite != wr)
          stable = 1'b0;
        pen++;
      end
      @(posedge clk); #1;
    end
    e = sb.pop_front();
    chk("wait_states", 32'(waits), 32'(e.waits));
    chk("penable_cycles", 32'(pen), 32'(e.pen));
    chk("psel_access", 32'(c_psel), 32'(e.psel));
    chk("paddr_access", c_paddr, addr);
    if (wr) chk("pwdata_access", c_pwdata, wd);
    chk("apb_stable", 32'(stable), 32'd1);
    chk("psel_onehot", 32'(onehot), 32'd1);
    chk("hresp_last_wait", 32'(resp_lo), 32'(e.resp));
    chk("hresp_final", 32'(hresp), 32'(e.resp));
    chk("hrdata", hrdata, e.rdata);
  endtask

  task automatic idle_cycle();
    hsel = 1'b0; htrans = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hreadyout"}, 32'(hreadyout), 32'd1);
    chk({tag, "_hresp"},     32'(hresp),     32'd0);
    chk({tag, "_psel"},      32'(psel),      32'd0);
    chk({tag, "_penable"},   32'(penable),   32'd0);
    chk({tag, "_pwrite"},    32'(pwrite),    32'd0);
    chk({tag, "_paddr"},     paddr,          32'd0);
    chk({tag, "_pwdata"},    pwdata,         32'd0);
    chk({tag, "_hrdata"},    hrdata,         32'd0);
  endtask

  initial begin
    rst = 1'b1; hsel = 1'b0; hsel3 = 1'b0; hready = 1'b1; hwrite = 1'b0;
    haddr = '0; hwdata = '0; htrans = 2'b00;
    noise = 1'b0; pulse0 = 1'b0; slv_err = '0; slv_hang = '0;
    for (int i = 0; i < 4; i++) begin
      slv_wait[i] = 0;
      slv_rd[i]   = 32'h1000_0000 + 32'(i);
    end
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    idle_cycle();

    // Zero-wait write to slave 2.
    xfer(32'h0000_2010, 1'b1, 32'hA5A5_1234);
    idle_cycle();

    // Read from slave 1 with 2 wait cycles while other slaves shout ready/error.
    slv_wait[1] = 2; slv_rd[1] = 32'hDEAD_BEEF; noise = 1'b1;
    xfer(32'h0000_1004, 1'b0, 32'h0);
    noise = 1'b0;
    idle_cycle();

    // Slave error, then a back-to-back read issued during ERR2.
    slv_err[3] = 1'b1; slv_rd[0] = 32'h1111_2222;
    xfer(32'h0000_3008, 1'b0, 32'h0);
    slv_err[3] = 1'b0;
    xfer(32'h0000_0020, 1'b0, 32'h0);
    idle_cycle();

    // Timeout on a hung slave; a late PREADY must do nothing.
    slv_hang[0] = 1'b1;
    xfer(32'h0000_0040, 1'b1, 32'h0000_0055);
    slv_rd[0] = 32'hBAD0_BAD0; pulse0 = 1'b1;
    @(posedge clk); #1;
    pulse0 = 1'b0; slv_hang[0] = 1'b0;
    chk("late_ready_hreadyout", 32'(hreadyout), 32'd1);
    chk("late_ready_hresp", 32'(hresp), 32'd0);
    chk("late_ready_psel", 32'(psel), 32'd0);
    chk("late_ready_hrdata", hrdata, m_hrdata);

    // IDLE/BUSY with HSEL, and NONSEQ without HSEL: no APB activity.
    for (int k = 0; k < 3; k++) begin
      hsel = (k != 2); htrans = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b10;
      haddr = 32'h0000_2000;
      @(posedge clk); #1;
      chk("nop_hreadyout", 32'(hreadyout), 32'd1);
      chk("nop_hresp", 32'(hresp), 32'd0);
      chk("nop_psel", 32'(psel), 32'd0);
    end
    idle_cycle();

    // Unmapped index on the 3-slave bridge.
    hsel3 = 1'b1; htrans = 2'b10; haddr = 32'h0000_3000; hwrite = 1'b0;
    @(posedge clk); #1;
    hsel3 = 1'b0; htrans = 2'b00;
    chk("unmap_t1_hreadyout", 32'(hreadyout3), 32'd0);
    chk("unmap_t1_psel", 32'(psel3), 32'd0);
    @(posedge clk); #1;
    chk("unmap_err1_hreadyout", 32'(hreadyout3), 32'd0);
    chk("unmap_err1_hresp", 32'(hresp3), 32'd1);
    chk("unmap_err1_psel", 32'(psel3), 32'd0);
    @(posedge clk); #1;
    chk("unmap_err2_hreadyout", 32'(hreadyout3), 32'd1);
    chk("unmap_err2_hresp", 32'(hresp3), 32'd1);
    chk("unmap_err2_psel", 32'(psel3), 32'd0);
    @(posedge clk); #1;
    chk("unmap_done_hresp", 32'(hresp3), 32'd0);

    // Reset in the middle of a write's ACCESS phase.
    slv_wait[1] = 5;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_1100; hwrite = 1'b1;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hCAFE_F00D;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_penable", 32'(penable), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("midreset");
    rst = 1'b0; m_hrdata = '0;
    idle_cycle();

    // Recovery read after reset.
    slv_wait[2] = 1; slv_rd[2] = 32'h0BAD_CAFE;
    xfer(32'h0000_2000, 1'b0, 32'h0);
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ahb2apb3_mux_bridge.md
AHB2APB3_MUX_BRIDGE -- requirements
Module: ahb2apb3_mux_bridge

Interface
REQ-001 Parameter ADDR_W, 32, width of HADDR and PADDR.
REQ-002 Parameter DATA_W, 32, width of HWDATA, HRDATA, PWDATA and each PRDATA lane; legal values are 8, 16 and 32.
REQ-003 Parameter NUM_SLV, 4, number of APB slaves; legal range is 1..16.
REQ-004 Parameter SLV_AW, 12, address bits per slave window; slave index = HADDR[SLV_AW+IDX_W-1:SLV_AW], where IDX_W = max(1, clog2(NUM_SLV)).
REQ-005 Parameter TIMEOUT, 256, number of ACCESS cycles before a forced error; 0 disables the timeout.
REQ-006 The block SHALL have one clock; reset is synchronous and active-high.
REQ-007 HCLK  in  1  clock; all logic on the rising edge.
REQ-008 HRESET  in  1  synchronous, active-high reset.
REQ-009 HSEL, HREADY  in  1  AHB select; bus-wide ready.
REQ-010 HADDR  in  ADDR_W;  HTRANS  in  2;  HWRITE  in  1;  HWDATA  in  DATA_W  (AHB-Lite slave inputs).
REQ-011 HRDATA  out  DATA_W;  HREADYOUT  out  1;  HRESP  out  2  (00=OKAY, 01=ERROR).
REQ-012 PADDR  out  ADDR_W;  PWRITE, PENABLE  out  1;  PWDATA  out  DATA_W.
REQ-013 PSEL  out  NUM_SLV  one-hot select.
REQ-014 PRDATA  in  NUM_SLV*DATA_W, with slave i on lane i;  PREADY, PSLVERR  in  NUM_SLV.

Function
REQ-015 The FSM SHALL have the states IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
REQ-016 A valid transfer SHALL be HSEL & HREADY & HTRANS[1], sampled in IDLE or ERR2; on a valid transfer the block latches HADDR, HWRITE and the slave index, then moves to WDATA.
REQ-017 An IDLE or BUSY HTRANS, or HSEL=0, SHALL cause no APB activity and a zero-wait OKAY response.
REQ-018 In WDATA the block SHALL capture HWDATA into PWDATA (writes only) and hold HREADYOUT=0; next state is SETUP, or ERR1 if the latched index is >= NUM_SLV.
REQ-019 In SETUP the block SHALL assert PSEL[idx]=1 and PENABLE=0, hold HREADYOUT=0, and move unconditionally to ACCESS.
REQ-020 In ACCESS the block SHALL assert PSEL[idx]=1 and PENABLE=1 and hold PADDR, PWRITE and PWDATA stable until the access completes.
REQ-021 ACCESS with PREADY[idx]=1 and PSLVERR[idx]=0 SHALL register PRDATA lane idx into HRDATA (reads) and go to IDLE, where HREADYOUT=1 and HRESP=OKAY.
REQ-022 ACCESS with PREADY[idx]=1 and PSLVERR[idx]=1 SHALL go to ERR1.
REQ-023 ERR1 SHALL drive HRESP=ERROR, HREADYOUT=0 and PSEL=0.
REQ-024 ERR2 SHALL drive HRESP=ERROR and HREADYOUT=1, then go to IDLE, or to WDATA if a valid transfer is sampled.
REQ-025 A 16-bit wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with PREADY[idx]=0.
REQ-026 When TIMEOUT>0 and the wait counter reaches TIMEOUT-1 with PREADY still low, the block SHALL go to ERR1, drop PSEL and ignore any late PREADY.
REQ-027 Minimum latency SHALL be 3 wait states on AHB: address phase T0; T1=WDATA, T2=SETUP, T3=ACCESS with HREADYOUT=0; T4 HREADYOUT=1.
REQ-028 PREADY, PSLVERR and PRDATA from non-selected slaves SHALL be ignored.
REQ-029 At most one PSEL bit SHALL be high in any cycle.
REQ-030 HRDATA SHALL hold its last registered value outside a completing read.

Reset
REQ-031 On HRESET=1 at a clock edge the block SHALL go to IDLE, including mid-transfer, and abort any APB access without completion.
REQ-032 Reset values SHALL be: HREADYOUT=1, HRESP=00, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, HRDATA=0, wait counter 0.

Structure
REQ-033 Package ahb2apb3_pkg SHALL hold the state enum, the HTRANS codes (IDLE/BUSY/NONSEQ/SEQ) and the HRESP codes.
REQ-034 Sub-module apb3_slave_mux SHALL implement the one-hot PSEL decode and the PRDATA/PREADY/PSLVERR selection by index; the FSM and the registers stay in the top level.

Verification
REQ-035 Write 0xA5A5_1234 to 0x0000_2010 with NUM_SLV=4 and slave 2 zero-wait -> PSEL=0100, PADDR=0x2010, PWDATA=0xA5A5_1234, HREADYOUT low for 3 cycles, then OKAY.
REQ-036 Read 0x0000_1004 with slave 1 returning 0xDEAD_BEEF after 2 PREADY-low cycles -> HRDATA=0xDEAD_BEEF, 5 wait states, PENABLE high for 3 cycles.
REQ-037 Slave 3 returns PSLVERR=1 with PREADY=1 -> ERR1 (HRESP=01, HREADYOUT=0) then ERR2 (HRESP=01, HREADYOUT=1), then a back-to-back read to slave 0 in ERR2 completes OKAY.
REQ-038 TIMEOUT=8 and slave 0 holds PREADY=0 -> ERROR response after 8 ACCESS cycles, PSEL drops, and a PREADY pulse one cycle later has no effect.
REQ-039 With NUM_SLV=3, access to index 3 (0x3000) -> no PSEL bit asserted and a two-cycle ERROR response.
REQ-040 HRESET asserted during ACCESS of a write -> next cycle PSEL=0, PENABLE=0, HREADYOUT=1, and all outputs at reset values.
